// File: rtl/match_ctrl.sv
// match_ctrl -- two-player match sequencer for a paddle game.
//
// Controls the match flow IDLE -> SERVE -> PLAY -> (PAUSE) -> POINT -> SERVE/OVER.
// It keeps the score, times the pre-serve countdown and the post-point hold
// in frame ticks, launches the ball, and gates paddle move pulses.
//
// Parameters:
//   WIN_SCORE    points that win a match (1..15)
//   SERVE_FRAMES frame ticks counted down before each serve (1..255)
//   POINT_FRAMES frame ticks held after a scored point (1..255)
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   frame_tick        one-cycle pulse per video frame
//   start_key         start pulse (IDLE: begin match, OVER: back to IDLE)
//   pause_key         pause toggle pulse (PLAY <-> PAUSE)
//   key_in[3:0]       move pulses {P2 left, P2 right, P1 left, P1 right}
//   miss_bottom       ball passed the bottom paddle (point to P2)
//   miss_top          ball passed the top paddle (point to P1)
//   key_flag[3:0]     move pulses delayed one cycle, live only in SERVE/PLAY
//   ball_en           ball motion enable (PLAY only)
//   ball_serve        one-cycle relaunch pulse
//   serve_dir         0 toward bottom (P1), 1 toward top (P2)
//   score1, score2    player scores
//   state[2:0]        IDLE=0 SERVE=1 PLAY=2 PAUSE=3 POINT=4 OVER=5
//   winner[1:0]       00 none, 01 P1, 10 P2
module match_ctrl #(
  parameter int unsigned WIN_SCORE    = 7,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned POINT_FRAMES = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start_key,
  input  logic       pause_key,
  input  logic [3:0] key_in,
  input  logic       miss_bottom,
  input  logic       miss_top,
  output logic [3:0] key_flag,
  output logic       ball_en,
  output logic       ball_serve,
  output logic       serve_dir,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [2:0] state,
  output logic [1:0] winner
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    PAUSE = 3'd3,
    POINT = 3'd4,
    OVER  = 3'd5
  } state_e;

  localparam logic [7:0] SERVE_CNT = 8'(SERVE_FRAMES);
  localparam logic [7:0] POINT_CNT = 8'(POINT_FRAMES);
  localparam logic [3:0] WIN       = 4'(WIN_SCORE);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] score1_q, score1_d;
  logic [3:0] score2_q, score2_d;
  logic [1:0] winner_q, winner_d;
  logic [3:0] key_flag_q, key_flag_d;
  logic       ball_en_q, ball_en_d;
  logic       ball_serve_q, ball_serve_d;
  logic       serve_dir_q, serve_dir_d;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    score1_d     = score1_q;
    score2_d     = score2_q;
    winner_d     = winner_q;
    serve_dir_d  = serve_dir_q;
    ball_serve_d = 1'b0;
    key_flag_d   = (state_q == SERVE || state_q == PLAY) ? key_in : '0;

    unique case (state_q)
      IDLE: begin
        score1_d = '0;
        score2_d = '0;
        if (start_key) begin
          state_d     = SERVE;
          cnt_d       = SERVE_CNT;
          serve_dir_d = 1'b0;
        end
      end
      SERVE: begin
        // The countdown is reloaded on the entry edge, so a tick on that
        // same edge never counts; the launch happens on the tick seen at 1.
        if (frame_tick) begin
          if (cnt_q == 8'd1) begin
            state_d      = PLAY;
            ball_serve_d = 1'b1;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      PLAY: begin
        // A miss outranks a simultaneous pause, which is simply dropped.
        if (miss_bottom && miss_top) begin
          state_d = POINT;
          cnt_d   = POINT_CNT;
        end else if (miss_bottom) begin
          state_d     = POINT;
          cnt_d       = POINT_CNT;
          score2_d    = score2_q + 4'd1;
          serve_dir_d = 1'b0;
        end else if (miss_top) begin
          state_d     = POINT;
          cnt_d       = POINT_CNT;
          score1_d    = score1_q + 4'd1;
          serve_dir_d = 1'b1;
        end else if (pause_key) begin
          state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (pause_key) state_d = PLAY;
      end
      POINT: begin
        if (frame_tick) begin
          if (cnt_q == 8'd1) begin
            if (score1_q == WIN || score2_q == WIN) begin
              state_d  = OVER;
              winner_d = (score1_q == WIN) ? 2'b01 : 2'b10;
            end else begin
              state_d = SERVE;
              cnt_d   = SERVE_CNT;
            end
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end
      OVER: begin
        if (start_key) begin
          state_d  = IDLE;
          score1_d = '0;
          score2_d = '0;
          winner_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    ball_en_d = (state_d == PLAY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      score1_q     <= '0;
      score2_q     <= '0;
      winner_q     <= '0;
      key_flag_q   <= '0;
      ball_en_q    <= 1'b0;
      ball_serve_q <= 1'b0;
      serve_dir_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      score1_q     <= score1_d;
      score2_q     <= score2_d;
      winner_q     <= winner_d;
      key_flag_q   <= key_flag_d;
      ball_en_q    <= ball_en_d;
      ball_serve_q <= ball_serve_d;
      serve_dir_q  <= serve_dir_d;
    end
  end

  assign state      = state_q;
  assign score1     = score1_q;
  assign score2     = score2_q;
  assign winner     = winner_q;
  assign key_flag   = key_flag_q;
  assign ball_en    = ball_en_q;
  assign ball_serve = ball_serve_q;
  assign serve_dir  = serve_dir_q;

endmodule

// File: tb/tb_match_ctrl.sv
// Scoreboard bench for match_ctrl with WIN_SCORE=2, SERVE_FRAMES=3,
// POINT_FRAMES=2. Stimulus pushes hand-computed expected output snapshots;
// a monitor pops and compares them on the falling clock edge.
module tb_match_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       start_key = 1'b0;
  logic       pause_key = 1'b0;
  logic [3:0] key_in = '0;
  logic       miss_bottom = 1'b0;
  logic       miss_top = 1'b0;
  logic [3:0] key_flag;
  logic       ball_en;
  logic       ball_serve;
  logic       serve_dir;
  logic [3:0] score1;
  logic [3:0] score2;
  logic [2:0] state;
  logic [1:0] winner;

  match_ctrl #(
    .WIN_SCORE   (2),
    .SERVE_FRAMES(3),
    .POINT_FRAMES(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .start_key  (start_key),
    .pause_key  (pause_key),
    .key_in     (key_in),
    .miss_bottom(miss_bottom),
    .miss_top   (miss_top),
    .key_flag   (key_flag),
    .ball_en    (ball_en),
    .ball_serve (ball_serve),
    .serve_dir  (serve_dir),
    .score1     (score1),
    .score2     (score2),
    .state      (state),
    .winner     (winner)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [2:0] st;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [1:0] win;
    logic [3:0] kf;
    logic       be;
    logic       bs;
    logic       sd;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Monitor: drains every pending expectation at the falling edge.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if ({state, score1, score2, winner, key_flag, ball_en, ball_serve, serve_dir} !==
          {e.st, e.s1, e.s2, e.win, e.kf, e.be, e.bs, e.sd}) begin
        errors++;
        $display("FAIL %s: got st=%0d s1=%0d s2=%0d win=%b kf=%b be=%b bs=%b sd=%b, expected st=%0d s1=%0d s2=%0d win=%b kf=%b be=%b bs=%b sd=%b",
                 e.name, state, score1, score2, winner, key_flag, ball_en, ball_serve, serve_dir,
                 e.st, e.s1, e.s2, e.win, e.kf, e.be, e.bs, e.sd);
      end
    end
  end

  task automatic ex(input string n, input logic [2:0] st, input logic [3:0] s1,
                    input logic [3:0] s2, input logic [1:0] w, input logic [3:0] kf,
                    input logic be, input logic bs, input logic sd);
    exp_t e;
    e.name = n; e.st = st; e.s1 = s1; e.s2 = s2; e.win = w;
    e.kf = kf; e.be = be; e.bs = bs; e.sd = sd;
    q.push_back(e);
  endtask

  // One clock edge with the currently driven inputs, then clear all pulses.
  task automatic tk();
    @(posedge clk);
    #1;
    frame_tick = 1'b0; start_key = 1'b0; pause_key = 1'b0;
    key_in = '0; miss_bottom = 1'b0; miss_top = 1'b0;
  endtask

  task automatic ft(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      tk();
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    ex("reset", 0, 0, 0, 2'b00, 4'h0, 0, 0, 0);
    tk();
    rst = 1'b0;

    frame_tick = 1; pause_key = 1; key_in = 4'hF; tk();
    ex("idle_ignore", 0, 0, 0, 2'b00, 4'h0, 0, 0, 0);

    // Tick on the entry edge must not count.
    start_key = 1; frame_tick = 1; tk();
    ex("start", 1, 0, 0, 2'b00, 4'h0, 0, 0, 0);
    key_in = 4'h1; frame_tick = 1; tk();
    ex("serve_key", 1, 0, 0, 2'b00, 4'h1, 0, 0, 0);
    frame_tick = 1; tk();
    ex("serve_cnt", 1, 0, 0, 2'b00, 4'h0, 0, 0, 0);
    tk();
    ex("serve_hold", 1, 0, 0, 2'b00, 4'h0, 0, 0, 0);
    frame_tick = 1; tk();
    ex("serve_launch", 2, 0, 0, 2'b00, 4'h0, 1, 1, 0);
    tk();
    ex("play", 2, 0, 0, 2'b00, 4'h0, 1, 0, 0);

    miss_top = 1; tk();
    ex("miss_top", 4, 1, 0, 2'b00, 4'h0, 0, 0, 1);
    frame_tick = 1; tk();
    ex("point_hold", 4, 1, 0, 2'b00, 4'h0, 0, 0, 1);
    frame_tick = 1; tk();
    ex("point_exit", 1, 1, 0, 2'b00, 4'h0, 0, 0, 1);
    ft(2); frame_tick = 1; tk();
    ex("serve2", 2, 1, 0, 2'b00, 4'h0, 1, 1, 1);

    miss_top = 1; miss_bottom = 1; tk();
    ex("both_miss", 4, 1, 0, 2'b00, 4'h0, 0, 0, 1);
    ft(2);
    ft(2); frame_tick = 1; tk();
    ex("serve3", 2, 1, 0, 2'b00, 4'h0, 1, 1, 1);

    pause_key = 1; tk();
    ex("pause", 3, 1, 0, 2'b00, 4'h0, 0, 0, 1);
    key_in = 4'h3; miss_bottom = 1; start_key = 1; frame_tick = 1; tk();
    ex("pause_ignore", 3, 1, 0, 2'b00, 4'h0, 0, 0, 1);
    pause_key = 1; key_in = 4'h3; tk();
    ex("resume", 2, 1, 0, 2'b00, 4'h0, 1, 0, 1);
    key_in = 4'h4; tk();
    ex("key_pass", 2, 1, 0, 2'b00, 4'h4, 1, 0, 1);
    key_in = 4'hF; tk();
    ex("key_oppose", 2, 1, 0, 2'b00, 4'hF, 1, 0, 1);

    miss_bottom = 1; pause_key = 1; tk();
    ex("miss_beats_pause", 4, 1, 1, 2'b00, 4'h0, 0, 0, 0);
    ft(2);
    ex("point_to_serve", 1, 1, 1, 2'b00, 4'h0, 0, 0, 0);
    ft(2); frame_tick = 1; tk();
    ex("serve4", 2, 1, 1, 2'b00, 4'h0, 1, 1, 0);

    miss_bottom = 1; tk();
    ex("win_point", 4, 1, 2, 2'b00, 4'h0, 0, 0, 0);
    ft(2);
    ex("over", 5, 1, 2, 2'b10, 4'h0, 0, 0, 0);
    pause_key = 1; frame_tick = 1; key_in = 4'h1; tk();
    ex("over_ignore", 5, 1, 2, 2'b10, 4'h0, 0, 0, 0);
    start_key = 1; tk();
    ex("over_restart", 0, 0, 0, 2'b00, 4'h0, 0, 0, 0);

    // Reset asserted mid-cycle during POINT must act before the next edge.
    start_key = 1; tk();
    ft(2); frame_tick = 1; tk();
    miss_bottom = 1; tk();
    ex("pre_reset", 4, 0, 1, 2'b00, 4'h0, 0, 0, 0);
    tk();
    rst = 1'b1;
    ex("async_reset", 0, 0, 0, 2'b00, 4'h0, 0, 0, 0);
    frame_tick = 1; tk();
    ex("reset_hold", 0, 0, 0, 2'b00, 4'h0, 0, 0, 0);
    rst = 1'b0;
    tk();
    ex("after_reset", 0, 0, 0, 2'b00, 4'h0, 0, 0, 0);
    start_key = 1; tk();
    ex("restart", 1, 0, 0, 2'b00, 4'h0, 0, 0, 0);

    repeat (2) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
